// File: rtl/peak_sample_source.sv
// Frame transmitter: buffers up to K signed samples, then streams them to the peak finder under send_data/stop flow control.
// Optional build macro SKIP_NEG_EN: drop negative samples at load time.
module peak_sample_source #(
    parameter int N  = 16,
    parameter int K  = 42,
    parameter int AW = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [N-1:0] wr_data,
    input  logic         start,
    input  logic         send_data,
    input  logic         stop,
    output logic         ready,
    output logic [N-1:0] data_out,
    output logic         data_valid,
    output logic         frame_done,
    output logic         wr_full,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_SEND,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic          ready_q, ready_d;
    logic          data_valid_q, data_valid_d;
    logic          frame_done_q, frame_done_d;
    logic [N-1:0]  data_out_q, data_out_d;

    logic [N-1:0]  buf_mem [K];

    logic          grant;
    logic          has_room;
    logic          sign_ok;
    logic          wr_accept;
    logic [AW-1:0] last_idx;

    assign grant    = send_data & ~stop;
    assign has_room = (wp_q < AW'(K));
    assign last_idx = wp_q - AW'(1);

`ifdef SKIP_NEG_EN
    assign sign_ok = ~wr_data[N-1];
`else
    assign sign_ok = 1'b1;
`endif

    assign wr_accept = (state_q == S_IDLE) & wr_en & has_room & sign_ok;

    // Sample storage is never reset; contents are only read below wp.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            buf_mem[wp_q] <= wr_data;
        end
    end

    always_comb begin
        state_d      = state_q;
        wp_d         = wp_q;
        rp_d         = rp_q;
        ready_d      = ready_q;
        data_valid_d = 1'b0;
        frame_done_d = 1'b0;
        data_out_d   = data_out_q;

        case (state_q)
            S_IDLE: begin
                if (wr_accept) begin
                    wp_d = wp_q + AW'(1);
                end
                // A write accepted on the same edge as start counts toward a non-empty frame.
                if (start && ((wp_q != '0) || wr_accept)) begin
                    state_d = S_ARMED;
                    ready_d = 1'b1;
                end
            end
            S_ARMED: begin
                if (grant) begin
                    state_d = S_SEND;
                    rp_d    = '0;
                end
            end
            S_SEND: begin
                if (grant) begin
                    data_out_d   = buf_mem[rp_q];
                    data_valid_d = 1'b1;
                    rp_d         = rp_q + AW'(1);
                    if (rp_q == last_idx) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                ready_d      = 1'b0;
                wp_d         = '0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wp_q         <= '0;
            rp_q         <= '0;
            ready_q      <= 1'b0;
            data_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            data_out_q   <= '0;
        end else begin
            state_q      <= state_d;
            wp_q         <= wp_d;
            rp_q         <= rp_d;
            ready_q      <= ready_d;
            data_valid_q <= data_valid_d;
            frame_done_q <= frame_done_d;
            data_out_q   <= data_out_d;
        end
    end

    assign ready      = ready_q;
    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_done = frame_done_q;
    assign wr_full    = (wp_q == AW'(K));
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_peak_sample_source.sv
// Directed + randomized bench for peak_sample_source; the reference model is a sample queue plus grant counting.
module tb_peak_sample_source;

    localparam int N  = 16;
    localparam int K  = 42;
    localparam int AW = 6;

`ifdef SKIP_NEG_EN
    localparam bit SKIP_NEG = 1'b1;
`else
    localparam bit SKIP_NEG = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_en;
    logic [N-1:0] wr_data;
    logic         start;
    logic         send_data;
    logic         stop;
    logic         ready;
    logic [N-1:0] data_out;
    logic         data_valid;
    logic         frame_done;
    logic         wr_full;
    logic         busy;

    int passed = 0;
    int total  = 0;

    logic [N-1:0] exp_q[$];

    peak_sample_source #(.N(N), .K(K), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .start      (start),
        .send_data  (send_data),
        .stop       (stop),
        .ready      (ready),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_done (frame_done),
        .wr_full    (wr_full),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [N-1:0] v);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = v;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (exp_q.size() < K && !(SKIP_NEG && v[N-1])) exp_q.push_back(v);
        check("wr_full", {31'b0, wr_full}, {31'b0, exp_q.size() == K});
    endtask

    task automatic arm();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("arm_busy", {31'b0, busy}, {31'b0, exp_q.size() > 0});
        check("arm_ready", {31'b0, ready}, {31'b0, exp_q.size() > 0});
    endtask

    // mode 0: continuous grant; 1: stop for 2 cycles after 2nd sample; 2: random flow control
    task automatic run_frame(input int mode);
        int  m;
        int  sent;
        int  stalls;
        bit  armed;
        bit  done;
        bit  g;
        bit  exp_v;
        m      = exp_q.size();
        sent   = 0;
        stalls = 0;
        armed  = 1'b0;
        done   = 1'b0;
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            @(negedge clk);
            send_data = 1'b1;
            stop      = 1'b0;
            if (mode == 1 && sent == 2 && stalls < 2) begin
                stop = 1'b1;
                stalls++;
            end else if (mode == 2) begin
                send_data = ($urandom_range(0, 3) != 0);
                stop      = ($urandom_range(0, 3) == 0);
            end
            start = $urandom_range(0, 1);
            g = send_data && !stop;
            @(posedge clk);
            #1;
            if (sent == m) begin
                check("done_pulse", {31'b0, frame_done}, 32'd1);
                check("done_ready", {31'b0, ready}, 32'd0);
                check("done_valid", {31'b0, data_valid}, 32'd0);
                check("done_busy", {31'b0, busy}, 32'd0);
                done = 1'b1;
            end else begin
                exp_v = g && armed;
                if (g) armed = 1'b1;
                check("valid", {31'b0, data_valid}, {31'b0, exp_v});
                check("no_early_done", {31'b0, frame_done}, 32'd0);
                if (exp_v) begin
                    check("data", {16'b0, data_out}, {16'b0, exp_q[sent]});
                    sent++;
                end else if (sent > 0) begin
                    check("data_hold", {16'b0, data_out}, {16'b0, exp_q[sent-1]});
                end
            end
        end
        start     = 1'b0;
        send_data = 1'b0;
        stop      = 1'b0;
        if (!done) check("frame_timeout", 32'd0, 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        check("pulse_one_cycle", {31'b0, frame_done}, 32'd0);
    endtask

    initial begin
        int len;
        rst_n     = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        start     = 1'b0;
        send_data = 1'b0;
        stop      = 1'b0;
        #12;
        check("rst_ready", {31'b0, ready}, 32'd0);
        check("rst_valid", {31'b0, data_valid}, 32'd0);
        check("rst_data", {16'b0, data_out}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_full", {31'b0, wr_full}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of a frame
        load(16'd5); load(16'd9); load(16'd3); load(16'd7); load(16'd1);
        arm();
        @(negedge clk);
        send_data = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_data", {16'b0, data_out}, 32'd3);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_data", {16'b0, data_out}, 32'd0);
        check("async_rst_valid", {31'b0, data_valid}, 32'd0);
        check("async_rst_ready", {31'b0, ready}, 32'd0);
        check("async_rst_busy", {31'b0, busy}, 32'd0);
        check("async_rst_done", {31'b0, frame_done}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("post_rst_done", {31'b0, frame_done}, 32'd0);
            check("post_rst_busy", {31'b0, busy}, 32'd0);
            check("post_rst_valid", {31'b0, data_valid}, 32'd0);
        end
        send_data = 1'b0;

        // Start with an empty buffer is ignored
        arm();
        @(posedge clk);
        #1;
        check("empty_start_busy", {31'b0, busy}, 32'd0);

        // Basic frame, then the same frame with a stop window
        load(16'd5); load(16'd9); load(16'd3); load(16'd7); load(16'd1);
        arm();
        run_frame(0);
        load(16'd5); load(16'd9); load(16'd3); load(16'd7); load(16'd1);
        arm();
        run_frame(1);

        // Overfill: 43 writes, the last one dropped
        for (int i = 1; i <= 43; i++) load(N'(i));
        arm();
        run_frame(0);

        // Negative sample handling depends on the build
        load(16'd4); load(16'hFFFE); load(16'd6);
        arm();
        run_frame(0);

        // Randomized frames with random flow control
        for (int f = 0; f < 6; f++) begin
            len = $urandom_range(1, 45);
            for (int i = 0; i < len; i++) load(N'($urandom));
            arm();
            if (exp_q.size() > 0) run_frame(2);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
